// File: rtl/icache_pkg.sv
// Shared definitions for the dual-slot instruction cache.
//   fill_state_e   : refill FSM state encoding
//   DEF_LINES      : default number of direct-mapped lines
//   DEF_LINE_WORDS : default 32-bit words per line
//   NOP_WORD       : instruction word returned on a miss
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL1 = 2'd1,
    ST_FILL2 = 2'd2
  } fill_state_e;

  localparam int DEF_LINES      = 64;
  localparam int DEF_LINE_WORDS = 4;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/icache_dual_if.sv
// Refill bus between the instruction cache and backing memory.
//   mem_req   : cache requests a refill beat (held for the whole fill)
//   mem_addr  : word-aligned address of the requested beat
//   mem_ack   : memory accepts the beat; mem_rdata is valid this cycle
//   mem_rdata : refill word
// master = cache side, slave = memory side.
interface icache_dual_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/icache_refill_ctrl.sv
// Refill sequencer for icache_dual: picks the line to fetch, walks the beats
// of the line over the refill bus and tells the arrays what to update.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no refill; a miss on slot 1 (else slot 2) starts one
//   ST_FILL1 | refilling slot 1's line; may chain straight into ST_FILL2
//   ST_FILL2 | refilling slot 2's line; always returns to ST_IDLE
//
// Ports:
//   clk, clrn          : clock, async active-low reset
//   miss1/miss2        : lookup result per slot (1 = miss)
//   line1/line2        : line address (pc[31:2+log2(LINE_WORDS)]) per slot
//   flush              : invalidate-all request
//   mem                : refill bus (master side)
//   busy               : FSM is not idle
//   fill_start         : a refill begins at the next edge (write tag, clear valid)
//   start_line         : line address of the refill being started
//   fill_done          : last beat accepted this cycle (set valid)
//   done_idx           : index of the line being completed
//   wr_en / wr_addr    : data-array write strobe and word address
//   clear_all          : clear every valid bit at the next edge
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int IDX_W      = 6,
  parameter int BASE_W     = 28
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          miss1,
  input  logic                          miss2,
  input  logic [BASE_W-1:0]             line1,
  input  logic [BASE_W-1:0]             line2,
  input  logic                          flush,
  icache_dual_if.master                 mem,
  output logic                          busy,
  output logic                          fill_start,
  output logic [BASE_W-1:0]             start_line,
  output logic                          fill_done,
  output logic [IDX_W-1:0]              done_idx,
  output logic                          wr_en,
  output logic [IDX_W+$clog2(LINE_WORDS)-1:0] wr_addr,
  output logic                          clear_all
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int CNT_W = (OFF_W == 0) ? 1 : OFF_W;
  localparam int DA_W  = IDX_W + OFF_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  fill_state_e       state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [BASE_W-1:0] line_q, line_d;
  logic              req_q, req_d;
  logic [31:0]       addr_q, addr_d;
  logic              flush_pend_q, flush_pend_d;
  logic              ack;
  logic              last;

  always_comb begin
    ack          = req_q & mem.mem_ack;
    last         = ack & (beat_q == LAST_BEAT);
    state_d      = state_q;
    beat_d       = beat_q;
    line_d       = line_q;
    addr_d       = addr_q;
    flush_pend_d = flush_pend_q;
    fill_start   = 1'b0;
    start_line   = line1;
    clear_all    = 1'b0;

    if (state_q == ST_IDLE) begin
      // A flush that arrived mid-fill lands here, one cycle after the fill
      // ends, so the line that was just completed is invalidated too.
      clear_all    = flush | flush_pend_q;
      flush_pend_d = 1'b0;
      if (miss1) begin
        fill_start = 1'b1;
        start_line = line1;
        state_d    = ST_FILL1;
      end else if (miss2) begin
        fill_start = 1'b1;
        start_line = line2;
        state_d    = ST_FILL2;
      end
    end else begin
      flush_pend_d = flush_pend_q | flush;
      if (ack) begin
        beat_d = beat_q + CNT_W'(1);
        addr_d = addr_q + 32'd4;
      end
      if (last) begin
        state_d = ST_IDLE;
        // Slot 2 still misses on the line just filled only because valid is
        // not set until this edge; that case must not refill the line again.
        if (state_q == ST_FILL1 && miss2 && (line2 != line_q)) begin
          fill_start = 1'b1;
          start_line = line2;
          state_d    = ST_FILL2;
        end
      end
    end

    if (fill_start) begin
      line_d = start_line;
      beat_d = '0;
      addr_d = {30'(start_line) << OFF_W, 2'b00};
    end

    req_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      line_q       <= '0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      line_q       <= line_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign fill_done    = last;
  assign done_idx     = line_q[IDX_W-1:0];
  assign wr_en        = ack;
  assign wr_addr      = (DA_W'(line_q[IDX_W-1:0]) << OFF_W) | DA_W'(beat_q);
  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;

endmodule

// File: rtl/icache_dual.sv
// Dual-slot direct-mapped instruction cache. Two fetch addresses are looked
// up combinationally every cycle; misses are refilled one line at a time by
// icache_refill_ctrl.
// Ports:
//   clk, clrn    : clock, async active-low reset
//   pc1, pc2     : fetch addresses (pc[1:0] ignored)
//   inst1, inst2 : cached word on a hit, NOP_WORD on a miss
//   cache_miss   : stall request (either slot misses or a refill is running)
//   flush        : invalidate every line
//   mem          : refill bus (master side)
module icache_dual
  import icache_pkg::*;
#(
  parameter int LINES      = DEF_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [31:0]   pc1,
  input  logic [31:0]   pc2,
  output logic [31:0]   inst1,
  output logic [31:0]   inst2,
  output logic          cache_miss,
  input  logic          flush,
  icache_dual_if.master mem
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int BASE_W = 30 - OFF_W;
  localparam int TAG_W  = BASE_W - IDX_W;
  localparam int DA_W   = IDX_W + OFF_W;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES*LINE_WORDS];

  logic [BASE_W-1:0] line1, line2;
  logic [IDX_W-1:0]  idx1, idx2;
  logic [TAG_W-1:0]  tag1, tag2;
  logic [DA_W-1:0]   da1, da2;
  logic              hit1, hit2;

  logic              busy;
  logic              fill_start;
  logic [BASE_W-1:0] start_line;
  logic [IDX_W-1:0]  start_idx;
  logic [TAG_W-1:0]  start_tag;
  logic              fill_done;
  logic [IDX_W-1:0]  done_idx;
  logic              wr_en;
  logic [DA_W-1:0]   wr_addr;
  logic              clear_all;

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pc1[1:0], pc2[1:0]};

  assign line1 = pc1[31:2+OFF_W];
  assign line2 = pc2[31:2+OFF_W];
  assign idx1  = line1[IDX_W-1:0];
  assign idx2  = line2[IDX_W-1:0];
  assign tag1  = line1[BASE_W-1:IDX_W];
  assign tag2  = line2[BASE_W-1:IDX_W];
  // {index, offset} is simply the low word-address bits of the pc.
  assign da1   = pc1[DA_W+1:2];
  assign da2   = pc2[DA_W+1:2];

  assign hit1 = valid_q[idx1] && (tag_q[idx1] == tag1);
  assign hit2 = valid_q[idx2] && (tag_q[idx2] == tag2);

  assign inst1      = hit1 ? data_q[da1] : NOP_WORD;
  assign inst2      = hit2 ? data_q[da2] : NOP_WORD;
  assign cache_miss = ~hit1 | ~hit2 | busy;

  assign start_idx = start_line[IDX_W-1:0];
  assign start_tag = start_line[BASE_W-1:IDX_W];

  icache_refill_ctrl #(
    .LINE_WORDS (LINE_WORDS),
    .IDX_W      (IDX_W),
    .BASE_W     (BASE_W)
  ) u_refill (
    .clk        (clk),
    .clrn       (clrn),
    .miss1      (~hit1),
    .miss2      (~hit2),
    .line1      (line1),
    .line2      (line2),
    .flush      (flush),
    .mem        (mem),
    .busy       (busy),
    .fill_start (fill_start),
    .start_line (start_line),
    .fill_done  (fill_done),
    .done_idx   (done_idx),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .clear_all  (clear_all)
  );

  // When a fill of one line chains straight into a fill of another line on
  // the same index, the new fill's clear must beat the old fill's set: the
  // tag has just been overwritten, so the old data would otherwise appear
  // under the new tag.
  always_comb begin
    valid_d = valid_q;
    if (clear_all) valid_d = '0;
    if (fill_done) valid_d[done_idx] = 1'b1;
    if (fill_start) valid_d[start_idx] = 1'b0;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_start) tag_q[start_idx] <= start_tag;
    if (wr_en) data_q[wr_addr] <= mem.mem_rdata;
  end

endmodule

// File: tb/tb_icache_dual.sv
module tb_icache_dual;
  import icache_pkg::*;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [31:0] pc1 = 32'h0;
  logic [31:0] pc2 = 32'h0;
  logic [31:0] inst1, inst2;
  logic        cache_miss;
  logic        flush = 1'b0;

  icache_dual_if mem_if ();

  icache_dual #(.LINES(64), .LINE_WORDS(4)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .pc1        (pc1),
    .pc2        (pc2),
    .inst1      (inst1),
    .inst2      (inst2),
    .cache_miss (cache_miss),
    .flush      (flush),
    .mem        (mem_if)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_addr_q [$];
  int acks_seen = 0;
  int gap = 0;
  int wait_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic push_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(base + 32'(4 * i));
  endtask

  task automatic reset_dut();
    clrn = 1'b0;
    flush = 1'b0;
    exp_addr_q.delete();
    step();
    step();
    clrn = 1'b1;
  endtask

  // Memory model: acks after `gap` idle request cycles, returns mem_word of
  // the address; checks every requested address against the scoreboard.
  initial begin
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_if.mem_ack = 1'b0;
      if (clrn && mem_if.mem_req) begin
        if (exp_addr_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_beat: got addr 0x%08h expected no request", mem_if.mem_addr);
        end else if (wait_cnt >= gap) begin
          mem_if.mem_ack   = 1'b1;
          mem_if.mem_rdata = mem_word(mem_if.mem_addr);
          acks_seen++;
          wait_cnt = 0;
          check32("beat_addr", mem_if.mem_addr, exp_addr_q.pop_front());
        end else begin
          wait_cnt++;
          check32("addr_hold", mem_if.mem_addr, exp_addr_q[0]);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  typedef struct {
    logic        cold;
    logic [31:0] pc1;
    logic [31:0] pc2;
    int          gap;
    int          nlines;
    logic [31:0] line_a;
    logic [31:0] line_b;
    int          miss_cycles;
  } vec_t;

  task automatic run_vec(input vec_t v, input int id);
    int cnt;
    if (v.cold) reset_dut();
    else step();
    gap = v.gap;
    if (v.nlines >= 1) push_line(v.line_a);
    if (v.nlines >= 2) push_line(v.line_b);
    pc1 = v.pc1;
    pc2 = v.pc2;
    #1;
    cnt = 0;
    while (cache_miss && cnt < 200) begin
      cnt++;
      step();
      #1;
    end
    check_int($sformatf("v%0d_miss_cycles", id), cnt, v.miss_cycles);
    check32($sformatf("v%0d_inst1", id), inst1, mem_word(v.pc1 & ~32'h3));
    check32($sformatf("v%0d_inst2", id), inst2, mem_word(v.pc2 & ~32'h3));
    check_int($sformatf("v%0d_beats_left", id), exp_addr_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    int   base;
    int   guard;
    int   cnt;
    int   drops;

    vecs[0] = '{1'b1, 32'h0000_0100, 32'h0000_0104, 0, 1, 32'h0000_0100, 32'h0, 5};
    vecs[1] = '{1'b0, 32'h0000_0104, 32'h0000_0108, 0, 0, 32'h0, 32'h0, 0};
    vecs[2] = '{1'b0, 32'h0000_0100, 32'h0000_0520, 0, 1, 32'h0000_0520, 32'h0, 5};
    vecs[3] = '{1'b1, 32'h0000_010C, 32'h0000_0110, 0, 2, 32'h0000_0100, 32'h0000_0110, 9};
    vecs[4] = '{1'b1, 32'h0000_0200, 32'h0000_0208, 2, 1, 32'h0000_0200, 32'h0, 13};
    vecs[5] = '{1'b1, 32'h0000_03F0, 32'h0000_0400, 1, 2, 32'h0000_03F0, 32'h0000_0400, 17};
    vecs[6] = '{1'b1, 32'h7FFF_FFFC, 32'h7FFF_FFF0, 0, 1, 32'h7FFF_FFF0, 32'h0, 5};
    vecs[7] = '{1'b1, 32'hFFFF_FFF8, 32'h0000_000B, 0, 2, 32'hFFFF_FFF0, 32'h0000_0000, 9};

    // Reset state
    step();
    #1;
    check32("rst_mem_req", 32'(mem_if.mem_req), 32'h0);
    check32("rst_mem_addr", mem_if.mem_addr, 32'h0);
    check32("rst_inst1", inst1, NOP_WORD);
    check32("rst_inst2", inst2, NOP_WORD);
    check32("rst_cache_miss", 32'(cache_miss), 32'h1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Flush arriving mid-fill: fill completes, line valid for one cycle,
    // then everything is invalid and pc1 refills.
    reset_dut();
    gap = 0;
    push_line(32'h0000_0600);
    push_line(32'h0000_0600);
    base = acks_seen;
    pc1 = 32'h0000_0600;
    pc2 = 32'h0000_0604;
    guard = 0;
    while ((acks_seen - base) < 2 && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) timeout("flush_wait_beat2");
    flush = 1'b1;
    step();
    flush = 1'b0;
    guard = 0;
    while (mem_if.mem_req && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) timeout("flush_wait_idle");
    #1;
    check32("flush_hit_before_apply", 32'(cache_miss), 32'h0);
    check32("flush_inst1_before_apply", inst1, mem_word(32'h0000_0600));
    step();
    #1;
    check32("flush_cleared_miss", 32'(cache_miss), 32'h1);
    check32("flush_cleared_inst1", inst1, NOP_WORD);
    cnt = 0;
    while (cache_miss && cnt < 200) begin
      cnt++;
      step();
      #1;
    end
    check_int("flush_refill_cycles", cnt, 5);
    check32("flush_refill_inst1", inst1, mem_word(32'h0000_0600));
    check_int("flush_beats_left", exp_addr_q.size(), 0);

    // Reset in the middle of a fill: request drops at once, refill restarts
    // from word 0 afterwards.
    reset_dut();
    gap = 0;
    push_line(32'h0000_0700);
    base = acks_seen;
    pc1 = 32'h0000_0700;
    pc2 = 32'h0000_0704;
    guard = 0;
    while ((acks_seen - base) < 3 && guard < 50) begin
      step();
      guard++;
    end
    if (guard >= 50) timeout("rst_wait_beat3");
    clrn = 1'b0;
    #1;
    check32("midrst_mem_req", 32'(mem_if.mem_req), 32'h0);
    check32("midrst_mem_addr", mem_if.mem_addr, 32'h0);
    exp_addr_q.delete();
    push_line(32'h0000_0700);
    step();
    clrn = 1'b1;
    #1;
    cnt = 0;
    while (cache_miss && cnt < 200) begin
      cnt++;
      step();
      #1;
    end
    check_int("midrst_refill_cycles", cnt, 5);
    check32("midrst_inst1", inst1, mem_word(32'h0000_0700));
    check_int("midrst_beats_left", exp_addr_q.size(), 0);

    // Same index, different tags: alternating refills with cache_miss held;
    // moving pc2 onto pc1's line mid-fill lets it settle.
    reset_dut();
    gap = 0;
    push_line(32'h0000_0100);
    push_line(32'h0000_1100);
    push_line(32'h0000_0100);
    base = acks_seen;
    pc1 = 32'h0000_0100;
    pc2 = 32'h0000_1100;
    #1;
    drops = 0;
    guard = 0;
    while ((acks_seen - base) < 11 && guard < 100) begin
      if (!cache_miss) drops++;
      step();
      #1;
      guard++;
    end
    if (guard >= 100) timeout("thrash_wait");
    check_int("thrash_miss_drops", drops, 0);
    pc2 = 32'h0000_0104;
    guard = 0;
    while (cache_miss && guard < 100) begin
      step();
      #1;
      guard++;
    end
    if (guard >= 100) timeout("thrash_settle");
    check32("thrash_inst1", inst1, mem_word(32'h0000_0100));
    check32("thrash_inst2", inst2, mem_word(32'h0000_0104));
    check_int("thrash_beats_left", exp_addr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
